// File: rtl/axis_audio_gain.sv
// axis_audio_gain: stereo AXIS volume/mute stage with saturating fixed-point gain
module axis_audio_gain #(
    parameter int SAMPLE_WIDTH = 24,
    parameter int GAIN_WIDTH   = 8,
    parameter int FRAC_BITS    = 4
) (
    input  logic                  axis_clk,
    input  logic                  axis_resetn,
    input  logic [31:0]           s_axis_data,
    input  logic                  s_axis_valid,
    output logic                  s_axis_ready,
    input  logic                  s_axis_last,
    output logic [31:0]           m_axis_data,
    output logic                  m_axis_valid,
    input  logic                  m_axis_ready,
    output logic                  m_axis_last,
    input  logic [GAIN_WIDTH-1:0] gain,
    input  logic                  mute,
    input  logic                  clip_clear,
    output logic                  clip_flag
);
    localparam int PW = SAMPLE_WIDTH + GAIN_WIDTH + 1;

    typedef enum logic [2:0] {RX_L, RX_R, MUL, TX_L, TX_R} state_t;

    state_t                  state;
    logic [SAMPLE_WIDTH-1:0] smp_l, smp_r, res_r, sc_l, sc_r;
    logic                    clip_l, clip_r, acc;
    logic                    unused_bits;

    // Returns {saturated, result}: product floored by FRAC_BITS, clamped to the sample range
    function automatic logic [SAMPLE_WIDTH:0] scale(input logic [SAMPLE_WIDTH-1:0] s,
                                                    input logic [GAIN_WIDTH-1:0] g);
        logic signed [PW-1:0]     p;
        logic [PW-SAMPLE_WIDTH:0] hi;
        p  = PW'($signed(s)) * PW'($signed({1'b0, g}));
        p  = p >>> FRAC_BITS;
        hi = p[PW-1:SAMPLE_WIDTH-1];
        return (&hi || ~|hi) ? {1'b0, p[SAMPLE_WIDTH-1:0]}
                             : {1'b1, p[PW-1], {(SAMPLE_WIDTH-1){~p[PW-1]}}};
    endfunction

    assign unused_bits = ^s_axis_data[31:SAMPLE_WIDTH];
    assign acc = s_axis_valid && s_axis_ready;
    assign {clip_l, sc_l} = mute ? '0 : scale(smp_l, gain);
    assign {clip_r, sc_r} = mute ? '0 : scale(smp_r, gain);

    // Packet FSM: collect L/R, scale once in MUL, then present both words downstream
    always_ff @(posedge axis_clk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state        <= RX_L;
            s_axis_ready <= 1'b0;
            m_axis_valid <= 1'b0;
            m_axis_last  <= 1'b0;
            m_axis_data  <= '0;
            clip_flag    <= 1'b0;
            smp_l        <= '0;
            smp_r        <= '0;
            res_r        <= '0;
        end else begin
            clip_flag <= (state == MUL && (clip_l || clip_r)) || (clip_flag && !clip_clear);
            case (state)
                RX_L: begin
                    s_axis_ready <= 1'b1;
                    if (acc && !s_axis_last) begin
                        smp_l <= s_axis_data[SAMPLE_WIDTH-1:0];
                        state <= RX_R;
                    end
                end
                RX_R: begin
                    if (acc) begin
                        if (s_axis_last) begin
                            smp_r        <= s_axis_data[SAMPLE_WIDTH-1:0];
                            s_axis_ready <= 1'b0;
                            state        <= MUL;
                        end else begin
                            smp_l <= s_axis_data[SAMPLE_WIDTH-1:0];
                        end
                    end
                end
                MUL: begin
                    res_r        <= sc_r;
                    m_axis_data  <= 32'(sc_l);
                    m_axis_valid <= 1'b1;
                    m_axis_last  <= 1'b0;
                    state        <= TX_L;
                end
                TX_L: begin
                    if (m_axis_ready) begin
                        m_axis_data <= 32'(res_r);
                        m_axis_last <= 1'b1;
                        state       <= TX_R;
                    end
                end
                TX_R: begin
                    if (m_axis_ready) begin
                        m_axis_data  <= '0;
                        m_axis_valid <= 1'b0;
                        m_axis_last  <= 1'b0;
                        s_axis_ready <= 1'b1;
                        state        <= RX_L;
                    end
                end
                default: state <= RX_L;
            endcase
        end
    end
endmodule

// File: tb/tb_axis_audio_gain.sv
// tb_axis_audio_gain: scoreboard bench with a packet-level reference model
module tb_axis_audio_gain;
    logic        axis_clk = 1'b0;
    logic        axis_resetn = 1'b0;
    logic [31:0] s_axis_data = '0;
    logic        s_axis_valid = 1'b0;
    logic        s_axis_ready;
    logic        s_axis_last = 1'b0;
    logic [31:0] m_axis_data;
    logic        m_axis_valid;
    logic        m_axis_ready = 1'b1;
    logic        m_axis_last;
    logic [7:0]  gain = 8'd16;
    logic        mute = 1'b0;
    logic        clip_clear = 1'b0;
    logic        clip_flag;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [32:0] exp_q[$];
    logic [32:0] mon_e;
    bit          exp_clip = 0;
    bit          have_left = 0;
    logic [23:0] left_v;
    bit          rand_ready = 0;

    axis_audio_gain dut (
        .axis_clk(axis_clk), .axis_resetn(axis_resetn),
        .s_axis_data(s_axis_data), .s_axis_valid(s_axis_valid),
        .s_axis_ready(s_axis_ready), .s_axis_last(s_axis_last),
        .m_axis_data(m_axis_data), .m_axis_valid(m_axis_valid),
        .m_axis_ready(m_axis_ready), .m_axis_last(m_axis_last),
        .gain(gain), .mute(mute), .clip_clear(clip_clear), .clip_flag(clip_flag)
    );

    always #5 axis_clk = ~axis_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: value * gain / 16 rounded toward -inf, clamped to 24-bit signed
    function automatic logic [23:0] ref_scale(input logic [23:0] s, input int g, input bit mt,
                                              output bit clip);
        longint v, q;
        clip = 0;
        if (mt) return 24'd0;
        v = longint'($signed(s)) * g;
        q = v / 16;
        if (v < 0 && q * 16 != v) q = q - 1;
        if (q > 8388607) begin q = 8388607; clip = 1; end
        if (q < -8388608) begin q = -8388608; clip = 1; end
        return q[23:0];
    endfunction

    task automatic model_beat(input logic [23:0] v, input bit last);
        bit cl, cr;
        logic [23:0] ol, orr;
        if (!have_left) begin
            if (!last) begin left_v = v; have_left = 1; end
        end else if (!last) begin
            left_v = v;
        end else begin
            ol  = ref_scale(left_v, int'(gain), mute, cl);
            orr = ref_scale(v, int'(gain), mute, cr);
            exp_q.push_back({1'b0, 8'h00, ol});
            exp_q.push_back({1'b1, 8'h00, orr});
            exp_clip = exp_clip | cl | cr;
            have_left = 0;
        end
    endtask

    task automatic tick();
        @(posedge axis_clk);
        #2;
    endtask

    task automatic send_beat(input logic [31:0] d, input bit last);
        int t;
        s_axis_data = d;
        s_axis_last = last;
        s_axis_valid = 1'b1;
        t = 0;
        @(negedge axis_clk);
        while (!s_axis_ready && t < 200) begin
            t++;
            @(negedge axis_clk);
        end
        if (t >= 200) check("s_ready_timeout", 32'(s_axis_ready), 32'd1);
        model_beat(d[23:0], last);
        tick();
        s_axis_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            t++;
            tick();
        end
        if (t >= 500) check("drain_timeout", 32'(exp_q.size()), 32'd0);
        tick();
    endtask

    task automatic wait_valid();
        int t;
        t = 0;
        while (!m_axis_valid && t < 50) begin
            t++;
            tick();
        end
        check("wait_valid", 32'(m_axis_valid), 32'd1);
    endtask

    // Randomised downstream backpressure, changed just after each edge
    always @(posedge axis_clk) begin
        #1;
        if (rand_ready) m_axis_ready = 1'($urandom_range(0, 1));
    end

    // Monitor: every accepted output beat is popped from the scoreboard and compared
    always @(negedge axis_clk) begin
        if (axis_resetn && m_axis_valid && m_axis_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_beat: got %h last %b expected no beat", m_axis_data, m_axis_last);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_data", m_axis_data, mon_e[31:0]);
                check("out_last", 32'(m_axis_last), 32'(mon_e[32]));
            end
        end
    end

    initial begin
        logic [31:0] hold_d;
        #3;
        check("rst_s_ready", 32'(s_axis_ready), 32'd0);
        check("rst_m_valid", 32'(m_axis_valid), 32'd0);
        check("rst_m_last", 32'(m_axis_last), 32'd0);
        check("rst_m_data", m_axis_data, 32'd0);
        check("rst_clip", 32'(clip_flag), 32'd0);
        tick();
        axis_resetn = 1'b1;
        tick();
        check("ready_after_rst", 32'(s_axis_ready), 32'd1);

        // 1: unity gain with latency check
        gain = 8'd16;
        send_beat(32'h0000_0100, 0);
        send_beat(32'h00FF_FF00, 1);
        check("lat_mul_cycle", 32'(m_axis_valid), 32'd0);
        tick();
        check("lat_valid", 32'(m_axis_valid), 32'd1);
        check("lat_s_ready", 32'(s_axis_ready), 32'd0);
        drain();
        check("t1_clip", 32'(clip_flag), 32'(exp_clip));

        // 2: saturation both ways, clip clear, mute
        gain = 8'd32;
        send_beat(32'h0050_0000, 0);
        send_beat(32'h0090_0000, 1);
        drain();
        check("t2_clip_set", 32'(clip_flag), 32'd1);
        clip_clear = 1'b1;
        tick();
        clip_clear = 1'b0;
        exp_clip = 0;
        check("t2_clip_clr", 32'(clip_flag), 32'd0);
        mute = 1'b1;
        send_beat(32'h0050_0000, 0);
        send_beat(32'h0090_0000, 1);
        tick();
        mute = 1'b0;
        drain();
        check("t2_mute_clip", 32'(clip_flag), 32'd0);

        // 3: floor rounding of negatives, upper byte ignored
        gain = 8'd8;
        send_beat(32'hABFF_FFFF, 0);
        send_beat(32'hAB00_0003, 1);
        drain();

        // 4: long downstream stall in TX_L
        gain = 8'd16;
        m_axis_ready = 1'b0;
        send_beat(32'h0012_3456, 0);
        send_beat(32'h0065_4321, 1);
        wait_valid();
        hold_d = m_axis_data;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("stall_data", m_axis_data, hold_d);
            check("stall_vl", {30'd0, m_axis_valid, m_axis_last}, 32'd2);
            check("stall_s_ready", 32'(s_axis_ready), 32'd0);
        end
        m_axis_ready = 1'b1;
        send_beat(32'h0000_0011, 0);
        send_beat(32'h0000_0022, 1);
        drain();

        // 5: orphan right word, then resync on repeated left
        send_beat(32'h0077_7777, 1);
        send_beat(32'h0011_1111, 0);
        send_beat(32'h0022_2222, 0);
        send_beat(32'h0033_3333, 1);
        drain();

        // 6: async reset while stalled in TX_R
        m_axis_ready = 1'b0;
        send_beat(32'h0000_0AAA, 0);
        send_beat(32'h0000_0BBB, 1);
        wait_valid();
        m_axis_ready = 1'b1;
        tick();
        m_axis_ready = 1'b0;
        tick();
        check("t6_in_tx_r", {30'd0, m_axis_valid, m_axis_last}, 32'd3);
        #1;
        axis_resetn = 1'b0;
        #1;
        check("t6_rst_valid", 32'(m_axis_valid), 32'd0);
        check("t6_rst_s_ready", 32'(s_axis_ready), 32'd0);
        exp_q.delete();
        have_left = 0;
        tick();
        axis_resetn = 1'b1;
        m_axis_ready = 1'b1;
        check("t6_ready_low", 32'(s_axis_ready), 32'd0);
        tick();
        check("t6_ready_back", 32'(s_axis_ready), 32'd1);
        send_beat(32'h0000_1234, 0);
        send_beat(32'h00FF_0000, 1);
        drain();

        // Random packets, framing glitches and backpressure
        rand_ready = 1;
        for (int p = 0; p < 40; p++) begin
            gain = 8'($urandom_range(0, 255));
            mute = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 5) == 0) send_beat($urandom, 1);
            if ($urandom_range(0, 5) == 0) send_beat($urandom, 0);
            send_beat($urandom, 0);
            send_beat($urandom, 1);
            tick();
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick();
        end
        drain();
        rand_ready = 0;
        m_axis_ready = 1'b1;
        check("rand_clip", 32'(clip_flag), 32'(exp_clip));
        clip_clear = 1'b1;
        tick();
        clip_clear = 1'b0;
        check("final_clip_clr", 32'(clip_flag), 32'd0);
        check("final_queue", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
